wb_burst_master: RTL and testbench

- Wishbone B3 burst initiator that drives the RAM or PCM slave port of the Nexys3 shared-bus memory controller.
- Accepts simple block-transfer commands (address, length, direction) from a local client such as a DMA, a boot loader or the memory self-test.
- Turns each command into one incrementing-address Wishbone burst.
- Write data is fully buffered before the burst starts, so the burst never stalls on the client. Read data is streamed back one beat per ack.

---
 rtl/wb_burst_master.sv | 222 ++++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator: turns one block-transfer command into one burst.
// Write data is buffered completely before the burst. Read data streams back one beat per ack.
module wb_burst_master #(
  parameter int BUF_ADDR_BITS = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     ram_clk_i,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [29:0]              cmd_addr,
  input  logic [BUF_ADDR_BITS-1:0] cmd_len,
  input  logic [3:0]               cmd_sel,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [31:0]              wr_data,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic                     done,
  output logic                     error,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [29:0]              wbm_addr_o,
  output logic [2:0]               wbm_cti_o,
  output logic [1:0]               wbm_bte_o,
  output logic [3:0]               wbm_sel_o,
  output logic [31:0]              wbm_data_o,
  input  logic [31:0]              wbm_data_i,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_err_i
);

  localparam int          DEPTH   = 1 << BUF_ADDR_BITS;
  localparam int          TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  CTI_INC = 3'b010;
  localparam logic [2:0]  CTI_END = 3'b111;

  typedef enum logic [1:0] {IDLE, FILL, BURST, FINISH} state_t;

  state_t                   r_state;
  logic [31:0]              r_buf [DEPTH];
  logic [BUF_ADDR_BITS-1:0] r_len;
  logic [BUF_ADDR_BITS-1:0] r_wptr;
  logic [BUF_ADDR_BITS-1:0] r_beat;
  logic [TMO_W-1:0]         r_tmo;
  logic                     r_cmd_we;
  logic [3:0]               r_cmd_sel;

  logic                     r_cmd_ready;
  logic                     r_wr_ready;
  logic                     r_rd_valid;
  logic [31:0]              r_rd_data;
  logic                     r_done;
  logic                     r_error;
  logic                     r_cyc;
  logic                     r_stb;
  logic                     r_we;
  logic [29:0]              r_addr;
  logic [2:0]               r_cti;
  logic [1:0]               r_bte;
  logic [3:0]               r_sel;
  logic [31:0]              r_data_o;

  logic                     w_cmd_hs;
  logic                     w_wr_hs;
  logic                     w_last_beat;
  logic                     w_tmo_hit;
  logic                     w_abort;
  logic [BUF_ADDR_BITS-1:0] w_next_beat;
  logic [31:0]              w_first_wdata;

  function automatic logic [2:0] cti_for(input logic [BUF_ADDR_BITS-1:0] beat,
                                         input logic [BUF_ADDR_BITS-1:0] len);
    return (beat == len) ? CTI_END : CTI_INC;
  endfunction

  assign w_cmd_hs    = cmd_valid & r_cmd_ready;
  assign w_wr_hs     = wr_valid & r_wr_ready;
  assign w_last_beat = (r_beat == r_len);
  assign w_next_beat = r_beat + 1'b1;
  assign w_tmo_hit   = ~wbm_ack_i & (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_abort     = wbm_err_i | w_tmo_hit;
  // A one-beat write launches on the same edge that stores its only word.
  assign w_first_wdata = (r_wptr == '0) ? wr_data : r_buf[0];

  // Write buffer: data only, never reset.
  always_ff @(posedge ram_clk_i) begin
    if (r_state == FILL && w_wr_hs)
      r_buf[r_wptr] <= wr_data;
  end

  always_ff @(posedge ram_clk_i) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_wptr      <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_cmd_we    <= 1'b0;
      r_cmd_sel   <= '0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_cti       <= '0;
      r_bte       <= '0;
      r_sel       <= '0;
      r_data_o    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            r_error     <= 1'b0;
            r_len       <= cmd_len;
            r_cmd_we    <= cmd_we;
            r_cmd_sel   <= cmd_sel;
            r_addr      <= cmd_addr;
            r_beat      <= '0;
            r_wptr      <= '0;
            r_tmo       <= '0;
            if (cmd_we) begin
              r_wr_ready <= 1'b1;
              r_state    <= FILL;
            end else begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b0;
              r_sel   <= cmd_sel;
              r_bte   <= 2'b00;
              r_cti   <= cti_for('0, cmd_len);
              r_state <= BURST;
            end
          end
        end

        FILL: begin
          if (w_wr_hs) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_wptr == r_len) begin
              r_wr_ready <= 1'b0;
              r_cyc      <= 1'b1;
              r_stb      <= 1'b1;
              r_we       <= 1'b1;
              r_sel      <= r_cmd_sel;
              r_bte      <= 2'b00;
              r_cti      <= cti_for('0, r_len);
              r_data_o   <= w_first_wdata;
              r_state    <= BURST;
            end
          end
        end

        BURST: begin
          if (w_abort) begin
            // Error or timeout: drop the bus at once, discard remaining beats.
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_cti   <= '0;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else if (wbm_ack_i) begin
            r_tmo <= '0;
            if (!r_cmd_we) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= wbm_data_i;
            end
            if (w_last_beat) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_cti   <= '0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_beat   <= w_next_beat;
              r_addr   <= r_addr + 30'd1;
              r_cti    <= cti_for(w_next_beat, r_len);
              r_data_o <= r_buf[w_next_beat];
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        FINISH: begin
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign wr_ready   = r_wr_ready;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign done       = r_done;
  assign error      = r_error;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_stb;
  assign wbm_we_o   = r_we;
  assign wbm_addr_o = r_addr;
  assign wbm_cti_o  = r_cti;
  assign wbm_bte_o  = r_bte;
  assign wbm_sel_o  = r_sel;
  assign wbm_data_o = r_data_o;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: reads, max-length write, single beat, err, timeout, reset.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [29:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        error;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o;
  logic [31:0] wbm_data_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.BUF_ADDR_BITS(4), .TIMEOUT(16)) dut (
    .ram_clk_i(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .error(error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"},   32'(wbm_cyc_o),  32'd0);
    check({tag, "_stb"},   32'(wbm_stb_o),  32'd0);
    check({tag, "_we"},    32'(wbm_we_o),   32'd0);
    check({tag, "_addr"},  32'(wbm_addr_o), 32'd0);
    check({tag, "_cti"},   32'(wbm_cti_o),  32'd0);
    check({tag, "_sel"},   32'(wbm_sel_o),  32'd0);
    check({tag, "_datao"}, wbm_data_o,      32'd0);
    check({tag, "_ctl"},   32'({rd_valid, done, error, wr_ready, cmd_ready}), 32'd0);
    check({tag, "_rdata"}, rd_data,         32'd0);
  endtask

  task automatic issue(input logic we, input logic [29:0] a, input logic [3:0] l,
                       input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_sel   = s;
    step();
    cmd_valid = 1'b0;
    check("cmd_ready_drop", 32'(cmd_ready), 32'd0);
    check("error_clear",    32'(error),     32'd0);
  endtask

  // errbeat < 0: no error. The err beat also raises ack to show err wins.
  task automatic read_burst(input logic [29:0] a, input int l, input logic [3:0] s,
                            input int errbeat);
    int pulses = 0;
    logic [29:0] ea;
    issue(1'b0, a, 4'(l), s);
    for (int k = 0; k <= l; k++) begin
      ea = a + 30'(k);
      check("rd_cyc",  32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'b110);
      check("rd_addr", 32'(wbm_addr_o), 32'(ea));
      check("rd_cti",  32'(wbm_cti_o), (k == l) ? 32'd7 : 32'd2);
      check("rd_sel_bte", 32'({wbm_sel_o, wbm_bte_o}), 32'({s, 2'b00}));
      wbm_ack_i  = 1'b1;
      wbm_err_i  = (k == errbeat);
      wbm_data_i = 32'hC0DE_0000 + 32'(k);
      step();
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (rd_valid) pulses++;
      if (k == errbeat) begin
        check("rd_err_no_valid", 32'(rd_valid), 32'd0);
        break;
      end
      check("rd_data", rd_data, 32'hC0DE_0000 + 32'(k));
    end
    check("rd_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("rd_done",     32'(done),      32'd1);
    check("rd_error",    32'(error),     (errbeat >= 0) ? 32'd1 : 32'd0);
    check("rd_pulses",   32'(pulses),    (errbeat >= 0) ? 32'(errbeat) : 32'(l + 1));
    step();
    check("rd_done_once", 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    int stb_early;
    int cnt;
    int done_seen;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Four-beat read at 0x100
    read_burst(30'h100, 3, 4'hF, -1);

    // Max-length write with irregular wr_valid gaps
    issue(1'b1, 30'h40, 4'hF, 4'hF);
    check("fill_wr_ready", 32'(wr_ready), 32'd1);
    stb_early = 0;
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        if (wbm_stb_o || wbm_cyc_o) stb_early++;
        step();
      end
      if (wbm_stb_o || wbm_cyc_o) stb_early++;
      wr_valid = 1'b1;
      wr_data  = 32'(i);
      step();
      wr_valid = 1'b0;
    end
    check("fill_no_stb", 32'(stb_early), 32'd0);
    check("fill_wr_ready_off", 32'(wr_ready), 32'd0);
    for (int k = 0; k < 16; k++) begin
      check("wr_ctl",  32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'b111);
      check("wr_addr", 32'(wbm_addr_o), 32'h40 + 32'(k));
      check("wr_cti",  32'(wbm_cti_o), (k == 15) ? 32'd7 : 32'd2);
      check("wr_data", wbm_data_o, 32'(k));
      check("wr_no_done", 32'(done), 32'd0);
      wbm_ack_i = 1'b1;
      step();
      wbm_ack_i = 1'b0;
    end
    check("wr_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("wr_done",  32'({done, error, rd_valid}), 32'b100);
    step();
    check("wr_done_once", 32'(done), 32'd0);

    // Single beat, partial byte select
    read_burst(30'h2A5, 0, 4'b0011, -1);

    // err (with simultaneous ack) on beat 2 of an 8-beat read, across the address wrap
    read_burst(30'h3FFF_FFFF, 7, 4'hF, 2);
    read_burst(30'h500, 1, 4'hF, -1);

    // Silent slave: abort after TIMEOUT cycles
    issue(1'b0, 30'h200, 4'h0, 4'hF);
    cnt = 0;
    while (wbm_cyc_o && cnt < 40) begin
      cnt++;
      step();
    end
    check("tmo_cycles", 32'(cnt), 32'd16);
    check("tmo_done",   32'({done, error, rd_valid}), 32'b110);
    step();
    check("tmo_done_once", 32'(done), 32'd0);

    // Reset in the middle of a write burst
    issue(1'b1, 30'h300, 4'h3, 4'hF);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_0000 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    check("rstw_cyc", 32'(wbm_cyc_o), 32'd1);
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    check("rstw_beat1_data", wbm_data_o, 32'hDEAD_0001);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    done_seen = 0;
    repeat (5) begin
      step();
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    read_burst(30'h10, 1, 4'hF, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
